// File: rtl/fetch_sequencer_if.sv
// ---------------------------------------------------------------------------
// fetch_sequencer_if
//   Bundles the request, fetch-control and IF/ID signals of the fetch
//   sequencer. The names follow the fetch stage and pipeline nets they
//   connect to.
//
//   Requester side (master modport, drives):
//     branchReq, branchTarget  absolute redirect from execute
//     trapReq                  level trap request, held until trapAck
//     stallReq                 decode cannot accept an instruction
//     instruction              word fetched at the current PC
//   Sequencer side (slave modport, drives):
//     pcVal, pcOverride        offset / active-low override to the fetch stage
//     trapAck, trapEpc         trap handshake and latched return address
//     fetchPc                  shadow copy of the fetch stage PC
//     ifIdInstr, ifIdValid     IF/ID pipeline register
// ---------------------------------------------------------------------------
interface fetch_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             branchReq;
  logic [WIDTH-1:0] branchTarget;
  logic             trapReq;
  logic             stallReq;
  logic [WIDTH-1:0] instruction;
  logic [WIDTH-1:0] pcVal;
  logic             pcOverride;
  logic             trapAck;
  logic [WIDTH-1:0] trapEpc;
  logic [WIDTH-1:0] fetchPc;
  logic [WIDTH-1:0] ifIdInstr;
  logic             ifIdValid;

  modport master (
    output branchReq, branchTarget, trapReq, stallReq, instruction,
    input  pcVal, pcOverride, trapAck, trapEpc, fetchPc, ifIdInstr, ifIdValid
  );

  modport slave (
    input  branchReq, branchTarget, trapReq, stallReq, instruction,
    output pcVal, pcOverride, trapAck, trapEpc, fetchPc, ifIdInstr, ifIdValid
  );
endinterface

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//   Sequences the program counter of an 8-bit fetch stage that only offers
//   a relative-offset override (pc <= pc + 1 + offset when pcOverride==0).
//   Arbitrates branch redirects, trap entry and decode stalls, mirrors the
//   fetch PC in a shadow register and owns the IF/ID register, squashing
//   the wrong-path word captured on a redirect.
//
//   Ports:
//     clk    rising-edge system clock
//     reset  asynchronous, active-low reset
//     bus    fetch_sequencer_if.slave (requests in, fetch control and
//            IF/ID register out)
// ---------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] TRAP_VECTOR = 8'hF0
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_sequencer_if.slave     bus
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state, state_next;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] epc_q;
  logic [WIDTH-1:0] instr_q;
  logic             valid_q;

  logic [WIDTH-1:0] pc_val;
  logic             pc_override;
  logic             trap_ack;
  logic             ifid_load;
  logic             ifid_valid_next;

  // The fetch stage always adds 1 on top of the offset, so reaching an
  // absolute target needs target - pc - 1.
  function automatic logic [WIDTH-1:0] offset_to(input logic [WIDTH-1:0] target,
                                                 input logic [WIDTH-1:0] pc);
    return target - pc - ONE;
  endfunction

  // NOTE: every output of this block gets a default before the case, so
  // no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next      = state;
    pc_val          = '0;
    pc_override     = 1'b1;
    trap_ack        = 1'b0;
    ifid_load       = 1'b0;
    ifid_valid_next = 1'b0;

    case (state)
      BOOT: begin
        state_next = RUN;
      end

      RUN, STALL: begin
        if (bus.branchReq) begin
          // Redirect wins even over a stall; the word fetched this cycle
          // is wrong-path, so it is captured but marked invalid.
          pc_override = 1'b0;
          pc_val      = offset_to(bus.branchTarget, pc_q);
          ifid_load   = 1'b1;
          state_next  = bus.stallReq ? STALL : RUN;
        end else if (bus.trapReq) begin
          pc_override = 1'b0;
          pc_val      = offset_to(TRAP_VECTOR, pc_q);
          trap_ack    = 1'b1;
          ifid_load   = 1'b1;
          state_next  = bus.stallReq ? STALL : RUN;
        end else if (bus.stallReq) begin
          // All-ones offset cancels the fetch stage's implicit +1.
          pc_override = 1'b0;
          pc_val      = '1;
          state_next  = STALL;
        end else begin
          ifid_load       = 1'b1;
          ifid_valid_next = 1'b1;
          state_next      = RUN;
        end
      end

      default: begin
        state_next = BOOT;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, exactly as the fetch stage does.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: the IF/ID register is reset as well, so a squashed or stale word
  // never reaches decode after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= '0;
      epc_q   <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q <= pc_q + ONE + (pc_override ? '0 : pc_val);
      if (trap_ack) begin
        epc_q <= pc_q;
      end
      if (ifid_load) begin
        instr_q <= bus.instruction;
        valid_q <= ifid_valid_next;
      end
    end
  end

  assign bus.pcVal      = pc_val;
  assign bus.pcOverride = pc_override;
  assign bus.trapAck    = trap_ack;
  assign bus.trapEpc    = epc_q;
  assign bus.fetchPc    = pc_q;
  assign bus.ifIdInstr  = instr_q;
  assign bus.ifIdValid  = valid_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
//   Directed bench for fetch_sequencer. Stimulus pushes hand-computed
//   expectations into a scoreboard queue; a monitor on the falling edge
//   pops and compares them against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;
  localparam int WIDTH = 8;

  typedef enum {S_PCVAL, S_OVR, S_ACK, S_EPC, S_PC, S_INSTR, S_VALID} sig_e;

  typedef struct {
    sig_e             sig;
    logic [WIDTH-1:0] val;
    string            name;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  logic clk = 1'b0;
  logic reset;

  fetch_sequencer_if #(.WIDTH(WIDTH)) bus ();

  fetch_sequencer #(
    .WIDTH      (WIDTH),
    .TRAP_VECTOR(8'hF0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Stand-in for the fetch stage memory: the word is a fixed function of
  // the fetch address, so expected IF/ID contents are computable by hand.
  assign bus.instruction = bus.fetchPc ^ 8'h5A;

  function automatic logic [WIDTH-1:0] observe(input sig_e s);
    case (s)
      S_PCVAL: return bus.pcVal;
      S_OVR:   return {{(WIDTH-1){1'b0}}, bus.pcOverride};
      S_ACK:   return {{(WIDTH-1){1'b0}}, bus.trapAck};
      S_EPC:   return bus.trapEpc;
      S_PC:    return bus.fetchPc;
      S_INSTR: return bus.ifIdInstr;
      default: return {{(WIDTH-1){1'b0}}, bus.ifIdValid};
    endcase
  endfunction

  task automatic check(input sig_e s, input logic [WIDTH-1:0] v, input string n);
    exp_t e;
    e.sig  = s;
    e.val  = v;
    e.name = n;
    sb.push_back(e);
  endtask

  task automatic drive(input logic br, input logic [WIDTH-1:0] tgt,
                       input logic tr, input logic st);
    bus.branchReq    = br;
    bus.branchTarget = tgt;
    bus.trapReq      = tr;
    bus.stallReq     = st;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every queued expectation against the live outputs.
  always @(negedge clk) begin
    exp_t             e;
    logic [WIDTH-1:0] act;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      act = observe(e.sig);
      tests++;
      if (act !== e.val) begin
        fails++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.val);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    reset = 1'b0;
    // Requests during reset must not leak to the combinational outputs.
    drive(1'b1, 8'h77, 1'b1, 1'b1);
    tick();
    tick();
    check(S_PC,    8'h00, "rst_pc");
    check(S_VALID, 8'h00, "rst_valid");
    check(S_INSTR, 8'h00, "rst_instr");
    check(S_EPC,   8'h00, "rst_epc");
    check(S_OVR,   8'h01, "rst_ovr");
    check(S_PCVAL, 8'h00, "rst_pcval");
    check(S_ACK,   8'h00, "rst_ack");
    tick();

    // BOOT cycle.
    reset = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check(S_PC,    8'h00, "boot_pc");
    check(S_VALID, 8'h00, "boot_valid");
    check(S_OVR,   8'h01, "boot_ovr");
    check(S_PCVAL, 8'h00, "boot_pcval");
    tick();
    check(S_PC,    8'h01, "seq_pc1");
    check(S_VALID, 8'h00, "seq_valid1");
    tick();
    check(S_PC,    8'h02, "seq_pc2");
    check(S_VALID, 8'h01, "seq_valid2");
    check(S_INSTR, 8'h5B, "seq_instr2");
    tick();

    // Branch to 0x05, then 0x05 -> 0x20.
    drive(1'b1, 8'h05, 1'b0, 1'b0);
    check(S_PC,    8'h03, "seq_pc3");
    check(S_INSTR, 8'h58, "seq_instr3");
    check(S_PCVAL, 8'h01, "br05_pcval");
    check(S_OVR,   8'h00, "br05_ovr");
    tick();
    drive(1'b1, 8'h20, 1'b0, 1'b0);
    check(S_PC,    8'h05, "br05_pc");
    check(S_VALID, 8'h00, "br05_squash");
    check(S_INSTR, 8'h59, "br05_instr");
    check(S_PCVAL, 8'h1A, "br20_pcval");
    check(S_OVR,   8'h00, "br20_ovr");
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check(S_PC,    8'h20, "br20_pc");
    check(S_VALID, 8'h00, "br20_squash");
    tick();

    // Set up a valid IF/ID word at PC 0x10, then stall three cycles.
    drive(1'b1, 8'h0F, 1'b0, 1'b0);
    check(S_PC,    8'h21, "br20_next_pc");
    check(S_VALID, 8'h01, "br20_valid_again");
    check(S_INSTR, 8'h7A, "br20_instr");
    check(S_PCVAL, 8'hED, "br0f_pcval");
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check(S_PC,    8'h0F, "br0f_pc");
    check(S_INSTR, 8'h7B, "br0f_instr");
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      check(S_PCVAL, 8'hFF, "stall_pcval");
      check(S_OVR,   8'h00, "stall_ovr");
      check(S_PC,    8'h10, "stall_pc");
      check(S_VALID, 8'h01, "stall_valid");
      check(S_INSTR, 8'h55, "stall_instr");
      tick();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check(S_OVR,   8'h01, "release_ovr");
    check(S_PCVAL, 8'h00, "release_pcval");
    check(S_PC,    8'h10, "release_pc");
    check(S_INSTR, 8'h55, "release_instr");
    tick();

    // Branch to 0x30, then trap.
    drive(1'b1, 8'h30, 1'b0, 1'b0);
    check(S_PC,    8'h11, "release_next_pc");
    check(S_INSTR, 8'h4A, "release_next_instr");
    check(S_PCVAL, 8'h1E, "br30_pcval");
    tick();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check(S_PC,    8'h30, "trap_pc");
    check(S_PCVAL, 8'hBF, "trap_pcval");
    check(S_OVR,   8'h00, "trap_ovr");
    check(S_ACK,   8'h01, "trap_ack");
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check(S_ACK,   8'h00, "trap_ack_pulse");
    check(S_EPC,   8'h30, "trap_epc");
    check(S_PC,    8'hF0, "trap_vec_pc");
    check(S_VALID, 8'h00, "trap_squash");
    check(S_OVR,   8'h01, "trap_after_ovr");
    tick();

    // Branch and trap together: branch wins, trap serviced next cycle.
    drive(1'b1, 8'h40, 1'b1, 1'b0);
    check(S_PC,    8'hF1, "bt_pc0");
    check(S_VALID, 8'h01, "bt_valid0");
    check(S_INSTR, 8'hAA, "bt_instr0");
    check(S_PCVAL, 8'h4E, "bt_pcval");
    check(S_ACK,   8'h00, "bt_no_ack");
    tick();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check(S_PC,    8'h40, "bt_pc1");
    check(S_EPC,   8'h30, "bt_epc_hold");
    check(S_ACK,   8'h01, "bt_ack");
    check(S_PCVAL, 8'hAF, "bt_trap_pcval");
    tick();

    // Wrap: 0xF0 -> 0xFE -> 0x02.
    drive(1'b1, 8'hFE, 1'b0, 1'b0);
    check(S_EPC,   8'h40, "bt_epc");
    check(S_PC,    8'hF0, "bt_vec_pc");
    check(S_ACK,   8'h00, "bt_ack_drop");
    check(S_PCVAL, 8'h0D, "brfe_pcval");
    tick();
    drive(1'b1, 8'h02, 1'b0, 1'b0);
    check(S_PC,    8'hFE, "wrap_pc0");
    check(S_PCVAL, 8'h03, "wrap_pcval");
    tick();

    // Branch arriving while stalled, stall still high afterwards.
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    check(S_PC,    8'h02, "wrap_pc1");
    check(S_VALID, 8'h00, "wrap_squash");
    check(S_PCVAL, 8'hFF, "stall2_pcval");
    tick();
    drive(1'b1, 8'h50, 1'b0, 1'b1);
    check(S_PC,    8'h02, "stall2_pc");
    check(S_INSTR, 8'hA4, "stall2_instr");
    check(S_PCVAL, 8'h4D, "stall_br_pcval");
    check(S_OVR,   8'h00, "stall_br_ovr");
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    check(S_PC,    8'h50, "stall_br_pc");
    check(S_PCVAL, 8'hFF, "stall_br_hold");
    check(S_INSTR, 8'h58, "stall_br_instr");
    tick();

    // Reset mid-stall: outputs must clear before any clock edge.
    #2;
    reset = 1'b0;
    check(S_PC,    8'h00, "midrst_pc");
    check(S_INSTR, 8'h00, "midrst_instr");
    check(S_VALID, 8'h00, "midrst_valid");
    check(S_EPC,   8'h00, "midrst_epc");
    check(S_OVR,   8'h01, "midrst_ovr");
    check(S_PCVAL, 8'h00, "midrst_pcval");
    check(S_ACK,   8'h00, "midrst_ack");
    tick();
    reset = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check(S_PC,    8'h00, "reboot_pc");
    check(S_OVR,   8'h01, "reboot_ovr");
    tick();
    check(S_PC,    8'h01, "reboot_pc1");
    check(S_VALID, 8'h00, "reboot_valid1");
    tick();
    tick();

    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
